pool2d_multi: RTL
=================

// Module: pool2d_multi
// PURPOSE
//  Streaming 2-D pooling stage for the LeNet-5 datapath, placed after each conv/ReLU stage.
//  - Accepts raster-order feature-map pixels, CH channels in parallel per beat.
//  - Emits one pooled result per channel for every complete PxP window (stride = P).
//  - Supports max pooling and, when AVG_POOL_EN is compiled in, average pooling; selected per frame.
//  - Generalises the fixed 2x2 single-channel unsigned max pool in width, window size, channel count, signedness and mode.
// PARAMETERS
//  BW      20  data width per channel
//  CH      4   channels processed in parallel
//  I_SIZE  24  input feature-map width = height
//  P_SIZE  2   window size and stride (>=2); must be a power of 2 when AVG_POOL_EN is defined
//  SIGNED  0   1: two's-complement compare and add; 0: unsigned
//  Derived localparam O_SIZE = floor(I_SIZE/P_SIZE).
// PORTS
//  clk           in   1       clock, rising edge
//  global_rst_n  in   1       asynchronous active-low reset
//  rst           in   1       synchronous soft clear (frame abort)
//  ce            in   1       input beat valid; one pixel (all CH) accepted per cycle with ce=1
//  i_mode        in   1       0=max, 1=avg; sampled on the first beat of a frame, held for that frame
//  i_data        in   CH*BW   pixel data; channel k at [k*BW +: BW]
//  o_data        out  CH*BW   pooled result, same packing; registered
//  o_valid       out  1       one-cycle strobe, o_data valid
//  o_end         out  1       one-cycle pulse, frame complete
// BEHAVIOUR
//  Reset state (global_rst_n=0, asynchronous; or rst=1, synchronous, with priority over ce):
//  - o_valid=0, o_end=0, o_data=0.
//  - All counters cleared, FSM in IDLE.
//  - Accumulator RAM is not cleared; it is overwritten at each window start.
//  Counters (advance only on ce=1):
//  - col 0..I_SIZE-1, row 0..I_SIZE-1.
//  - wc/wr = position inside the window; oc = output column.
//  - col wraps to 0 and row increments at col=I_SIZE-1.
//  FSM:
//  - IDLE: first ce -> RUN; latch i_mode.
//  - RUN: beat at row=col=I_SIZE-1 -> IDLE; o_end=1 next cycle.
//  - ce=1 in the cycle o_end is high is accepted as pixel (0,0) of the next frame.
//  Datapath, per channel:
//  - Horizontal register h: at wc=0, h=x; otherwise h=op(h,x).
//  - At wc=P-1, merge into line accumulator acc[oc] (O_SIZE entries x CH x BW_ACC): at wr=0, acc[oc]=op(h,x); otherwise acc[oc]=op(acc[oc],op(h,x)).
//  - At wr=P-1 and wc=P-1: o_data<=final(op(acc[oc],op(h,x))) and o_valid<=1 on the next edge.
//  - Latency = 1 cycle after the last pixel of a window.
//  - op = max (ties return either operand; values are equal) or add (avg mode).
//  - BW_ACC = BW in max mode; BW+2*clog2(P_SIZE) in avg mode (no overflow).
//  - final(avg) = sum >>> 2*clog2(P_SIZE): arithmetic shift when SIGNED=1, logical otherwise. Floor rounding, truncated to BW.
//  Boundary conditions:
//  - Trailing columns (col >= O_SIZE*P_SIZE) and trailing rows (row >= O_SIZE*P_SIZE) are consumed but produce no output.
//  - o_end still fires after the last frame pixel, so o_end may follow the last o_valid by several cycles.
//  - When I_SIZE%P_SIZE==0, the final o_valid and o_end are high in the same cycle.
//  - ce gaps of any length do not change results or order; no o_valid without a preceding ce.
//  - rst mid-frame discards the partial frame: no o_valid or o_end for it; the next ce is pixel (0,0).
//  - i_mode changes mid-frame are ignored.
//  - Exactly O_SIZE*O_SIZE o_valid strobes per frame.
// CONFIGURATION
//  AVG_POOL_EN defined:
//  - i_mode honoured; adder and wide accumulator instantiated.
//  - Elaboration error if P_SIZE is not a power of 2.
//  AVG_POOL_EN undefined:
//  - i_mode ignored; block is max-only.
//  - Accumulator width is BW; no adders synthesised.
// TESTING  (BW=8, CH=1, I_SIZE=4, P_SIZE=2, SIGNED=0 unless stated)
//  1. Max, stream 0..15 on consecutive cycles:
//     - o_valid one cycle after pixels 5, 7, 13, 15 with o_data 5, 7, 13, 15.
//     - o_end with the last strobe.
//  2. Avg (AVG_POOL_EN, i_mode=1), same stream: o_data 2, 4, 10, 12; same timing as scenario 1.
//  3. I_SIZE=5, stream 0..24:
//     - 4 strobes with o_data 6, 8, 16, 18.
//     - o_end one cycle after pixel 24 with o_valid=0.
//  4. SIGNED=1, CH=2:
//     - Window ch0 {-3,-7,-1,-9}, ch1 {-2,-2,-2,-3}: max -> ch0=-1, ch1=-2.
//     - Avg on the same window: ch0=-5, ch1=-3 (floor).
//  5. ce toggled 1-0-0-1 randomly through scenario 1: identical o_data sequence, o_valid only after ce beats.
//  6. Reset mid-frame:
//     - rst after pixel 9: no further o_valid or o_end for that frame.
//     - A following full frame behaves as scenario 1.
//     - global_rst_n pulse mid-frame: all outputs 0 immediately.

Source files
------------

// File: rtl/pool2d_multi_if.sv
// Pixel stream in / pooled stream out bundle for pool2d_multi.
// slave = pooling block side, master = producer/consumer side.
interface pool2d_multi_if #(
  parameter int BW = 20,
  parameter int CH = 4
);
  logic              ce;
  logic              i_mode;
  logic [CH*BW-1:0]  i_data;
  logic [CH*BW-1:0]  o_data;
  logic              o_valid;
  logic              o_end;

  modport slave  (input ce, i_mode, i_data, output o_data, o_valid, o_end);
  modport master (output ce, i_mode, i_data, input o_data, o_valid, o_end);
endinterface

// File: rtl/pool2d_multi.sv
// Streaming PxP/stride-P max (or avg with AVG_POOL_EN) pooling over CH parallel channels.
// Latency 1 cycle after a window's last pixel; no backpressure, every ce beat is consumed.
module pool2d_multi #(
  parameter int BW     = 20,
  parameter int CH     = 4,
  parameter int I_SIZE = 24,
  parameter int P_SIZE = 2,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          rst,
  pool2d_multi_if.slave bus
);

  localparam int O_SIZE = I_SIZE / P_SIZE;
  localparam int CW     = (I_SIZE > 1) ? $clog2(I_SIZE) : 1;
  localparam int WW     = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;
  localparam int OCW    = (O_SIZE > 1) ? $clog2(O_SIZE) : 1;
`ifdef AVG_POOL_EN
  localparam int SH     = 2 * $clog2(P_SIZE);
  localparam int BW_ACC = BW + SH;
`else
  localparam int BW_ACC = BW;
`endif

  localparam logic [CW-1:0]  COL_LAST = CW'(I_SIZE - 1);
  localparam logic [CW-1:0]  WIN_LIM  = CW'(O_SIZE * P_SIZE - 1);
  localparam logic [WW-1:0]  W_LAST   = WW'(P_SIZE - 1);
  localparam logic [OCW-1:0] OC_LAST  = OCW'(O_SIZE - 1);

  typedef logic [BW_ACC-1:0] acc_t;
  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, row_q, row_d;
  logic [WW-1:0]    wc_q, wc_d, wr_q, wr_d;
  logic [OCW-1:0]   oc_q, oc_d;
  logic [CH*BW-1:0] o_data_q, o_data_d;
  logic             o_valid_q, o_valid_d, o_end_q, o_end_d;
  logic             in_col, in_row, win_end, last_col, last_row;

  acc_t xe [CH];
  acc_t hx [CH];
  acc_t wv [CH];
  acc_t h_q [CH];
  acc_t acc_q [O_SIZE][CH];

`ifdef AVG_POOL_EN
  if ((P_SIZE & (P_SIZE - 1)) != 0) begin : g_p_check
    $error("pool2d_multi: P_SIZE must be a power of 2 when average pooling is enabled");
  end

  logic mode_q, mode_d, cur_avg;
  // The first beat of a frame uses i_mode directly; it is latched on that same beat.
  assign cur_avg = (state_q == IDLE) ? bus.i_mode : mode_q;
`else
  logic unused_mode;
  assign unused_mode = bus.i_mode;
`endif

  function automatic acc_t ext(input logic [BW-1:0] x);
    if (SIGNED != 0) return acc_t'($signed(x));
    return acc_t'(x);
  endfunction

  function automatic acc_t op(input acc_t a, input acc_t b);
`ifdef AVG_POOL_EN
    if (cur_avg) return a + b;
`endif
    if (SIGNED != 0) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  function automatic logic [BW-1:0] fin(input acc_t s);
    acc_t r;
    r = s;
`ifdef AVG_POOL_EN
    if (cur_avg) begin
      if (SIGNED != 0) r = acc_t'($signed(s) >>> SH);
      else             r = s >> SH;
    end
`endif
    return r[BW-1:0];
  endfunction

  if (O_SIZE * P_SIZE == I_SIZE) begin : g_full
    assign in_col = 1'b1;
    assign in_row = 1'b1;
  end else begin : g_trail
    assign in_col = (col_q <= WIN_LIM);
    assign in_row = (row_q <= WIN_LIM);
  end

  assign last_col = (col_q == COL_LAST);
  assign last_row = (row_q == COL_LAST);
  assign win_end  = in_col && in_row && (wc_q == W_LAST);

  always_comb begin
    for (int k = 0; k < CH; k++) begin
      xe[k] = ext(bus.i_data[k*BW +: BW]);
      hx[k] = (wc_q == '0) ? xe[k] : op(h_q[k], xe[k]);
      wv[k] = (wr_q == '0) ? hx[k] : op(acc_q[oc_q][k], hx[k]);
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    wc_d      = wc_q;
    wr_d      = wr_q;
    oc_d      = oc_q;
    o_data_d  = o_data_q;
    o_valid_d = 1'b0;
    o_end_d   = 1'b0;
`ifdef AVG_POOL_EN
    mode_d    = mode_q;
`endif
    if (rst) begin
      state_d  = IDLE;
      col_d    = '0;
      row_d    = '0;
      wc_d     = '0;
      wr_d     = '0;
      oc_d     = '0;
      o_data_d = '0;
    end else if (bus.ce) begin
      if (state_q == IDLE) begin
        state_d = RUN;
`ifdef AVG_POOL_EN
        mode_d  = bus.i_mode;
`endif
      end
      if (last_col) begin
        col_d = '0;
        wc_d  = '0;
        oc_d  = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
        wr_d  = (last_row || wr_q == W_LAST) ? '0 : wr_q + 1'b1;
        if (last_row) begin
          state_d = IDLE;
          o_end_d = 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
        if (wc_q == W_LAST) begin
          wc_d = '0;
          // Saturate so trailing columns never index past the line buffer.
          oc_d = (oc_q == OC_LAST) ? oc_q : oc_q + 1'b1;
        end else begin
          wc_d = wc_q + 1'b1;
        end
      end
      if (win_end && wr_q == W_LAST) begin
        o_valid_d = 1'b1;
        for (int k = 0; k < CH; k++) o_data_d[k*BW +: BW] = fin(wv[k]);
      end
    end
  end

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      wc_q      <= '0;
      wr_q      <= '0;
      oc_q      <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
      o_end_q   <= 1'b0;
`ifdef AVG_POOL_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      wc_q      <= wc_d;
      wr_q      <= wr_d;
      oc_q      <= oc_d;
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
      o_end_q   <= o_end_d;
`ifdef AVG_POOL_EN
      mode_q    <= mode_d;
`endif
    end
  end

  // Window storage is overwritten at every window start, so it needs no reset.
  always_ff @(posedge clk) begin
    if (bus.ce && !rst) begin
      for (int k = 0; k < CH; k++) begin
        h_q[k] <= hx[k];
        if (win_end) acc_q[oc_q][k] <= wv[k];
      end
    end
  end

  assign bus.o_data  = o_data_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_end   = o_end_q;

endmodule
